// File: rtl/cle_label_packer_pkg.sv
// Shared types, geometry constants and pixel-address helpers for the label packer.
package cle_label_packer_pkg;

  localparam int unsigned IMG_LOG2     = 5;
  localparam int unsigned IMG_DIM      = 32;
  localparam int unsigned PIX_PER_BYTE = 8;
  localparam int unsigned NUM_BYTES    = 128;
  localparam int unsigned PIX_ADDR_W   = 2 * IMG_LOG2;
  localparam int unsigned BYTE_ADDR_W  = PIX_ADDR_W - 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_EMIT,
    ST_DONE
  } st_e;

  typedef struct packed {
    logic [BYTE_ADDR_W-1:0]  a;
    logic [PIX_PER_BYTE-1:0] d;
  } byte_beat_t;

  function automatic logic [PIX_ADDR_W-1:0] pix_addr(input logic [BYTE_ADDR_W-1:0] byte_idx,
                                                     input logic [2:0]             bit_idx);
    return {byte_idx, bit_idx};
  endfunction

  function automatic logic [IMG_LOG2-1:0] pix_row(input logic [PIX_ADDR_W-1:0] pa);
    return pa[PIX_ADDR_W-1:IMG_LOG2];
  endfunction

  function automatic logic [IMG_LOG2-1:0] pix_col(input logic [PIX_ADDR_W-1:0] pa);
    return pa[IMG_LOG2-1:0];
  endfunction

endpackage

// File: rtl/cle_label_packer_if.sv
// Packed-byte output stream: address/data qualified by valid, accepted on valid&ready.
interface cle_label_packer_if #(
  parameter int unsigned A_W = 7,
  parameter int unsigned D_W = 8
);
  logic [A_W-1:0] out_a;
  logic [D_W-1:0] out_d;
  logic           out_valid;
  logic           out_ready;

  modport master (output out_a, output out_d, output out_valid, input out_ready);
  modport slave  (input out_a, input out_d, input out_valid, output out_ready);
endinterface

// File: rtl/cle_label_packer_bbox_tracker.sv
// Bounding box of all pixels hit during one scan; present only with CLE_BBOX_EN.
module cle_bbox_tracker
  import cle_label_packer_pkg::*;
#(
  parameter int unsigned DIM_LOG2 = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                pixel_hit,
  input  logic [DIM_LOG2-1:0] row,
  input  logic [DIM_LOG2-1:0] col,
  output logic [DIM_LOG2-1:0] min_row,
  output logic [DIM_LOG2-1:0] max_row,
  output logic [DIM_LOG2-1:0] min_col,
  output logic [DIM_LOG2-1:0] max_col,
  output logic                valid
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      min_row <= '1;
      max_row <= '0;
      min_col <= '1;
      max_col <= '0;
      valid   <= 1'b0;
    end else if (clear) begin
      min_row <= '1;
      max_row <= '0;
      min_col <= '1;
      max_col <= '0;
      valid   <= 1'b0;
    end else if (pixel_hit) begin
      if (row < min_row) min_row <= row;
      if (row > max_row) max_row <= row;
      if (col < min_col) min_col <= col;
      if (col > max_col) max_col <= col;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/cle_label_packer.sv
// Scans the 32x32 label SRAM and streams a 1-bit-per-pixel mask of one label plus a hit count.
// Optional CLE_BBOX_EN adds bounding-box outputs of the matching pixels.
module cle_label_packer
  import cle_label_packer_pkg::*;
#(
  parameter int unsigned LBL_W    = 8,
  parameter int unsigned DIM_LOG2 = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [LBL_W-1:0]        label,
  output logic [2*DIM_LOG2-1:0]   sram_a,
  input  logic [LBL_W-1:0]        sram_q,
  cle_label_packer_if.master      stream,
  output logic                    busy,
  output logic                    done,
  output logic [2*DIM_LOG2:0]     pix_count
`ifdef CLE_BBOX_EN
  ,
  output logic [DIM_LOG2-1:0]     bbox_min_row,
  output logic [DIM_LOG2-1:0]     bbox_max_row,
  output logic [DIM_LOG2-1:0]     bbox_min_col,
  output logic [DIM_LOG2-1:0]     bbox_max_col,
  output logic                    bbox_valid
`endif
);

  localparam int unsigned ADDR_W    = 2 * DIM_LOG2;
  localparam int unsigned BYTE_A_W  = ADDR_W - 3;
  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam int unsigned LAST_BYTE = (1 << BYTE_A_W) - 1;

  st_e                     state;
  logic [LBL_W-1:0]        label_r;
  logic [BYTE_A_W-1:0]     byte_idx;
  logic [3:0]              k;
  logic [PIX_PER_BYTE-1:0] sh;
  logic [BYTE_A_W-1:0]     out_a_r;
  logic [PIX_PER_BYTE-1:0] out_d_r;
  logic                    out_valid_r;
  logic                    hit_c;
  logic                    start_acc_c;

  // sram_q at step k belongs to the address issued at step k-1
  assign hit_c       = (state == ST_READ) && (k != 4'd0) && (sram_q == label_r);
  assign start_acc_c = (state == ST_IDLE) && start;

  assign stream.out_a     = out_a_r;
  assign stream.out_d     = out_d_r;
  assign stream.out_valid = out_valid_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      label_r     <= '0;
      byte_idx    <= '0;
      k           <= '0;
      sh          <= '0;
      sram_a      <= '0;
      out_a_r     <= '0;
      out_d_r     <= '0;
      out_valid_r <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pix_count   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            label_r   <= label;
            byte_idx  <= '0;
            k         <= '0;
            sh        <= '0;
            pix_count <= '0;
            sram_a    <= '0;
            busy      <= 1'b1;
            state     <= ST_READ;
          end
        end
        ST_READ: begin
          if (k < 4'd7) sram_a <= {byte_idx, 3'(k + 4'd1)};
          if (k != 4'd0) begin
            sh        <= {sh[PIX_PER_BYTE-2:0], hit_c};
            pix_count <= pix_count + CNT_W'(hit_c);
          end
          if (k == 4'd8) begin
            out_d_r     <= {sh[PIX_PER_BYTE-2:0], hit_c};
            out_a_r     <= byte_idx;
            out_valid_r <= 1'b1;
            state       <= ST_EMIT;
          end else begin
            k <= k + 4'd1;
          end
        end
        ST_EMIT: begin
          if (stream.out_ready) begin
            out_valid_r <= 1'b0;
            if (byte_idx == BYTE_A_W'(LAST_BYTE)) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              byte_idx <= byte_idx + BYTE_A_W'(1);
              sram_a   <= {byte_idx + BYTE_A_W'(1), 3'd0};
              k        <= '0;
              state    <= ST_READ;
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CLE_BBOX_EN
  logic [PIX_ADDR_W-1:0] hit_addr_c;
  assign hit_addr_c = pix_addr(byte_idx, 3'(k - 4'd1));

  cle_bbox_tracker #(.DIM_LOG2(DIM_LOG2)) u_bbox (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_acc_c),
    .pixel_hit (hit_c),
    .row       (pix_row(hit_addr_c)),
    .col       (pix_col(hit_addr_c)),
    .min_row   (bbox_min_row),
    .max_row   (bbox_max_row),
    .min_col   (bbox_min_col),
    .max_col   (bbox_max_col),
    .valid     (bbox_valid)
  );
`else
  logic unused_c;
  assign unused_c = start_acc_c;
`endif

endmodule

// File: tb/tb_cle_label_packer.sv
// Scoreboard bench for cle_label_packer: SRAM model, expected-byte queue, stall and timing checks.
module tb_cle_label_packer;
  import cle_label_packer_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] label;
  logic [9:0] sram_a;
  logic [7:0] sram_q = 8'd0;
  logic       busy, done;
  logic [10:0] pix_count;
`ifdef CLE_BBOX_EN
  logic [4:0] bb_min_row, bb_max_row, bb_min_col, bb_max_col;
  logic       bb_valid;
`endif

  cle_label_packer_if #(.A_W(7), .D_W(8)) bus ();

  cle_label_packer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .label     (label),
    .sram_a    (sram_a),
    .sram_q    (sram_q),
    .stream    (bus.master),
    .busy      (busy),
    .done      (done),
    .pix_count (pix_count)
`ifdef CLE_BBOX_EN
    ,
    .bbox_min_row (bb_min_row),
    .bbox_max_row (bb_max_row),
    .bbox_min_col (bb_min_col),
    .bbox_max_col (bb_max_col),
    .bbox_valid   (bb_valid)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] mem [1024];
  always @(posedge clk) sram_q <= mem[sram_a];

  int n_checks = 0;
  int n_fail   = 0;
  byte_beat_t q[$];
  int   exp_cnt;
  int   exp_rmin, exp_rmax, exp_cmin, exp_cmax;
  int   hs_count = 0;
  logic rnd_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference mask: bit 7-j of byte b is pixel b*8+j
  task automatic build_expect(input logic [7:0] lbl);
    q.delete();
    exp_cnt = 0;
    exp_rmin = 31; exp_rmax = 0; exp_cmin = 31; exp_cmax = 0;
    for (int b = 0; b < 128; b++) begin
      logic [7:0] d;
      d = 8'd0;
      for (int j = 0; j < 8; j++) begin
        int idx;
        idx = b * 8 + j;
        if (mem[idx] == lbl) begin
          d[7-j] = 1'b1;
          exp_cnt++;
          if (idx / 32 < exp_rmin) exp_rmin = idx / 32;
          if (idx / 32 > exp_rmax) exp_rmax = idx / 32;
          if (idx % 32 < exp_cmin) exp_cmin = idx % 32;
          if (idx % 32 > exp_cmax) exp_cmax = idx % 32;
        end
      end
      q.push_back('{a: 7'(b), d: d});
    end
  endtask

  task automatic check_reset_vals();
    check("rst_sram_a", 32'(sram_a), 32'd0);
    check("rst_out_a", 32'(bus.out_a), 32'd0);
    check("rst_out_d", 32'(bus.out_d), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pix_count", 32'(pix_count), 32'd0);
`ifdef CLE_BBOX_EN
    check("rst_bbox_min_row", 32'(bb_min_row), 32'd31);
    check("rst_bbox_max_col", 32'(bb_max_col), 32'd0);
    check("rst_bbox_valid", 32'(bb_valid), 32'd0);
`endif
  endtask

  // Full scan; poke_at > 0 pulses start with a different label mid-scan
  task automatic run_scan(input logic [7:0] lbl, input int poke_at);
    int cycles;
    build_expect(lbl);
    @(posedge clk); #1;
    start = 1'b1;
    label = lbl;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    cycles = 0;
    while (!done && cycles < 6000) begin
      @(posedge clk); #1;
      cycles++;
      start = (cycles == poke_at);
      label = (cycles == poke_at) ? ~lbl : lbl;
    end
    start = 1'b0;
    check("done_seen", 32'(done), 32'd1);
    if (!rnd_ready) check("scan_cycles", 32'(cycles), 32'd1280);
    check("pix_count", 32'(pix_count), 32'(exp_cnt));
    check("bytes_left", 32'(q.size()), 32'd0);
`ifdef CLE_BBOX_EN
    check("bbox_valid", 32'(bb_valid), 32'(exp_cnt != 0));
    check("bbox_min_row", 32'(bb_min_row), 32'(exp_rmin));
    check("bbox_max_row", 32'(bb_max_row), 32'(exp_rmax));
    check("bbox_min_col", 32'(bb_min_col), 32'(exp_cmin));
    check("bbox_max_col", 32'(bb_max_col), 32'(exp_cmax));
`endif
    @(posedge clk); #1;
    check("done_pulse_end", 32'(done), 32'd0);
    check("busy_end", 32'(busy), 32'd0);
    check("pix_count_hold", 32'(pix_count), 32'(exp_cnt));
  endtask

  // Sink: random or constant ready, changed just after each rising edge
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pop on handshake, hold data across stalls
  initial begin
    logic       stalled;
    logic [6:0] st_a;
    logic [7:0] st_d;
    byte_beat_t beat;
    stalled = 1'b0;
    st_a = '0;
    st_d = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("stall_valid", 32'(bus.out_valid), 32'd1);
          check("stall_a", 32'(bus.out_a), 32'(st_a));
          check("stall_d", 32'(bus.out_d), 32'(st_d));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            check("extra_byte", 32'(q.size()), 32'd1);
          end else begin
            beat = q.pop_front();
            check("out_a", 32'(bus.out_a), 32'(beat.a));
            check("out_d", 32'(bus.out_d), 32'(beat.d));
          end
          hs_count++;
          stalled = 1'b0;
        end else if (bus.out_valid) begin
          stalled = 1'b1;
          st_a = bus.out_a;
          st_d = bus.out_d;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin
    int guard;
    reset = 1'b0;
    start = 1'b0;
    label = 8'd0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    reset = 1'b1;

    // background mask of an all-zero map
    run_scan(8'd0, 0);

    // single pixel at row 5, col 10
    mem[5 * 32 + 10] = 8'd3;
    run_scan(8'd3, 0);

    // checkerboard under random backpressure
    for (int i = 0; i < 1024; i++) mem[i] = 8'(((i / 32) + (i % 32)) % 2);
    rnd_ready = 1'b1;
    run_scan(8'd1, 0);
    rnd_ready = 1'b0;

    // absent label
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom_range(0, 6));
    run_scan(8'd7, 0);

    // start while busy must be ignored
    run_scan(8'd4, 300);

    // reset while reading byte 40, then rescan
    build_expect(8'd2);
    hs_count = 0;
    @(posedge clk); #1;
    start = 1'b1;
    label = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (hs_count < 40 && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("reached_byte40", 32'(hs_count), 32'd40);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals();
    q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    run_scan(8'd2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
